// File: rtl/locked_mult_pkg.sv
// Shared types and constants for the locked-multiplier key sweeper.
// Holds the controller state encoding, LFSR definition and result widths.
package locked_mult_pkg;
  localparam int MULT_W = 8;
  localparam int RES_W  = 16;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400; // bits 15,13,12,10
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] NO_FAIL           = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_REPORT
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/mult_vec_gen.sv
// Test-vector source: 16-bit index counter plus Fibonacci LFSR.
// The selected register is split into the two 8-bit operands.
module mult_vec_gen
  import locked_mult_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              mode_i,
  output logic [15:0]       idx_o,
  output logic [MULT_W-1:0] op1_o,
  output logic [MULT_W-1:0] op2_o
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? LFSR_DEFAULT_SEED : LFSR_SEED;

  logic [15:0] idx_q, idx_d;
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    idx_d  = idx_q;
    lfsr_d = lfsr_q;
    if (load_i) begin
      idx_d  = 16'h0;
      lfsr_d = SEED;
    end else if (step_i) begin
      idx_d  = idx_q + 16'h1;
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= 16'h0;
      lfsr_q <= SEED;
    end else begin
      idx_q  <= idx_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign idx_o = idx_q;
  assign op1_o = mode_i ? idx_q[15:8] : lfsr_q[15:8];
  assign op2_o = mode_i ? idx_q[7:0]  : lfsr_q[7:0];
endmodule

// File: rtl/locked_mult_key_sweeper.sv
// Per-key sequencer for a key-locked 8x8 multiplier: applies a vector sweep,
// compares each settled result to an internal golden product, reports a verdict.
module locked_mult_key_sweeper
  import locked_mult_pkg::*;
#(
  parameter int          KEY_W         = 64,
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic              key_valid_i,
  output logic              key_ready_o,
  input  logic              vec_mode_i,
  output logic [MULT_W-1:0] mult_op1_o,
  output logic [MULT_W-1:0] mult_op2_o,
  output logic [KEY_W-1:0]  mult_key_o,
  input  logic [RES_W-1:0]  mult_result_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [KEY_W-1:0]  res_key_o,
  output logic [15:0]       res_err_cnt_o,
  output logic [15:0]       res_first_fail_o,
  output logic              res_pass_o,
  output logic              busy_o
);
  localparam int          SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);

  state_e              state_q, state_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                mode_q, mode_d;
  logic [MULT_W-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [RES_W-1:0]    golden_q, golden_d;
  logic [15:0]         err_q, err_d, first_q, first_d;
  logic                valid_q, valid_d, pass_q, pass_d;
  logic                ready_q, ready_d, busy_q, busy_d;

  logic                gen_load, gen_step;
  logic [15:0]         gen_idx;
  logic [MULT_W-1:0]   gen_op1, gen_op2;

  mult_vec_gen #(.LFSR_SEED(LFSR_SEED)) u_vec_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (gen_load),
    .step_i (gen_step),
    .mode_i (mode_q),
    .idx_o  (gen_idx),
    .op1_o  (gen_op1),
    .op2_o  (gen_op2)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    key_d    = key_q;
    mode_d   = mode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    golden_d = golden_q;
    err_d    = err_q;
    first_d  = first_q;
    valid_d  = valid_q;
    pass_d   = pass_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid_i && ready_q) begin
          key_d    = key_i;
          mode_d   = vec_mode_i;
          gen_load = 1'b1;
          err_d    = 16'h0;
          first_d  = NO_FAIL;
          pass_d   = 1'b0;
          state_d  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        op1_d    = gen_op1;
        op2_d    = gen_op2;
        golden_d = RES_W'(gen_op1) * RES_W'(gen_op2);
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
        else                         settle_d = settle_q + 1'b1;
      end
      ST_CHECK: begin
        if (mult_result_i != golden_q) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'h1;
          if (first_q == NO_FAIL) first_d = gen_idx;
        end
        // Terminate on compare so a full 65536-vector sweep never relies on wrap.
        if (gen_idx == LAST_IDX) begin
          valid_d = 1'b1;
          pass_d  = (err_d == 16'h0);
          state_d = ST_REPORT;
        end else begin
          gen_step = 1'b1;
          state_d  = ST_APPLY;
        end
      end
      ST_REPORT: begin
        if (res_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      key_q    <= '0;
      mode_q   <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      golden_q <= '0;
      err_q    <= 16'h0;
      first_q  <= NO_FAIL;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      golden_q <= golden_d;
      err_q    <= err_d;
      first_q  <= first_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign key_ready_o      = ready_q;
  assign busy_o           = busy_q;
  assign mult_op1_o       = op1_q;
  assign mult_op2_o       = op2_q;
  assign mult_key_o       = key_q;
  assign res_key_o        = key_q;
  assign res_valid_o      = valid_q;
  assign res_err_cnt_o    = err_q;
  assign res_first_fail_o = first_q;
  assign res_pass_o       = pass_q;
endmodule

// File: tb/tb_locked_mult_key_sweeper.sv
// Directed bench: two sweeper instances (256 and 4 vectors) driving a
// behavioural multiplier model with selectable fault injection.
module tb_locked_mult_key_sweeper;
  localparam logic [63:0] GOOD_KEY = 64'h4B72AAC6D650642F;
  localparam logic [63:0] BAD_KEY  = 64'h4B72AAC6D650640F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] key_in [2];
  logic        kv [2], vmode [2], rr [2];
  logic [15:0] mres [2];
  logic        kr [2], rv [2], rp [2], busy [2];
  logic [7:0]  op1 [2], op2 [2];
  logic [63:0] mkey [2], rkey [2];
  logic [15:0] err [2], ff [2];

  // 0 = ideal, 1 = invert bit0 unless key correct, 2 = invert bit0 when op2 == 2
  int model_mode = 0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [63:0] k, input int m);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    if (m == 1 && k != GOOD_KEY) p[0] = ~p[0];
    if (m == 2 && b == 8'h02)    p[0] = ~p[0];
    return p;
  endfunction

  always_comb mres[0] = model(op1[0], op2[0], mkey[0], model_mode);
  always_comb mres[1] = model(op1[1], op2[1], mkey[1], model_mode);

  locked_mult_key_sweeper #(.KEY_W(64), .NUM_VECTORS(256), .SETTLE_CYCLES(2), .LFSR_SEED(16'hACE1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .key_i(key_in[0]), .key_valid_i(kv[0]), .key_ready_o(kr[0]),
    .vec_mode_i(vmode[0]), .mult_op1_o(op1[0]), .mult_op2_o(op2[0]), .mult_key_o(mkey[0]),
    .mult_result_i(mres[0]), .res_valid_o(rv[0]), .res_ready_i(rr[0]), .res_key_o(rkey[0]),
    .res_err_cnt_o(err[0]), .res_first_fail_o(ff[0]), .res_pass_o(rp[0]), .busy_o(busy[0]));

  locked_mult_key_sweeper #(.KEY_W(64), .NUM_VECTORS(4), .SETTLE_CYCLES(2), .LFSR_SEED(16'hACE1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .key_i(key_in[1]), .key_valid_i(kv[1]), .key_ready_o(kr[1]),
    .vec_mode_i(vmode[1]), .mult_op1_o(op1[1]), .mult_op2_o(op2[1]), .mult_key_o(mkey[1]),
    .mult_result_i(mres[1]), .res_valid_o(rv[1]), .res_ready_i(rr[1]), .res_key_o(rkey[1]),
    .res_err_cnt_o(err[1]), .res_first_fail_o(ff[1]), .res_pass_o(rp[1]), .busy_o(busy[1]));

  // Offer a key for one edge; returns #1 after the accepting edge.
  task automatic start_key(input int d, input logic [63:0] k, input logic m);
    key_in[d] = k;
    vmode[d]  = m;
    kv[d]     = 1'b1;
    n_cmp++;
    if (kr[d] !== 1'b1) begin
      n_bad++;
      $display("FAIL start_ready dut%0d: key_ready=%b need 1", d, kr[d]);
    end
    @(posedge clk); #1;
    kv[d] = 1'b0;
  endtask

  // Cycle count includes the accept cycle and the first cycle res_valid is high.
  task automatic wait_verdict(input int d, output int cyc);
    cyc = 2;
    while (rv[d] !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (rv[d] !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL verdict_timeout dut%0d: res_valid=%b need 1", d, rv[d]);
    end
  endtask

  task automatic test_reset();
    n_cmp += 6;
    if (kr[0] !== 1'b1)       begin n_bad++; $display("FAIL rst_key_ready: %b need 1", kr[0]); end
    if (rv[0] !== 1'b0)       begin n_bad++; $display("FAIL rst_res_valid: %b need 0", rv[0]); end
    if (ff[0] !== 16'hFFFF)   begin n_bad++; $display("FAIL rst_first_fail: %h need ffff", ff[0]); end
    if (busy[0] !== 1'b0)     begin n_bad++; $display("FAIL rst_busy: %b need 0", busy[0]); end
    if ({op1[0], op2[0], err[0], rp[0]} !== 33'h0) begin
      n_bad++; $display("FAIL rst_ops_err_pass: %h %h %h %b need 0", op1[0], op2[0], err[0], rp[0]);
    end
    if (mkey[0] !== 64'h0)    begin n_bad++; $display("FAIL rst_key: %h need 0", mkey[0]); end
  endtask

  task automatic test_pass_counter();
    int cyc;
    model_mode = 0;
    start_key(0, GOOD_KEY, 1'b1);
    wait_verdict(0, cyc);
    n_cmp += 5;
    if (cyc != 1026)        begin n_bad++; $display("FAIL pass_latency: %0d need 1026", cyc); end
    if (err[0] !== 16'h0)   begin n_bad++; $display("FAIL pass_err: %h need 0", err[0]); end
    if (ff[0] !== 16'hFFFF) begin n_bad++; $display("FAIL pass_first: %h need ffff", ff[0]); end
    if (rp[0] !== 1'b1)     begin n_bad++; $display("FAIL pass_pass: %b need 1", rp[0]); end
    if (rkey[0] !== GOOD_KEY) begin n_bad++; $display("FAIL pass_key: %h need %h", rkey[0], GOOD_KEY); end
    @(posedge clk); #1;
    n_cmp += 2;
    if (rv[0] !== 1'b0) begin n_bad++; $display("FAIL pass_1cyc_handshake: valid=%b need 0", rv[0]); end
    if (kr[0] !== 1'b1) begin n_bad++; $display("FAIL pass_back_idle: ready=%b need 1", kr[0]); end
  endtask

  task automatic test_wrong_key();
    int cyc;
    model_mode = 1;
    start_key(1, BAD_KEY, 1'b1);
    wait_verdict(1, cyc);
    n_cmp += 5;
    if (cyc != 18)          begin n_bad++; $display("FAIL wkey_latency: %0d need 18", cyc); end
    if (err[1] !== 16'd4)   begin n_bad++; $display("FAIL wkey_err: %h need 4", err[1]); end
    if (ff[1] !== 16'd0)    begin n_bad++; $display("FAIL wkey_first: %h need 0", ff[1]); end
    if (rp[1] !== 1'b0)     begin n_bad++; $display("FAIL wkey_pass: %b need 0", rp[1]); end
    if (rkey[1] !== BAD_KEY) begin n_bad++; $display("FAIL wkey_key: %h need %h", rkey[1], BAD_KEY); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fail();
    int cyc;
    model_mode = 2;
    start_key(1, GOOD_KEY, 1'b1);
    wait_verdict(1, cyc);
    n_cmp += 3;
    if (err[1] !== 16'd1) begin n_bad++; $display("FAIL single_err: %h need 1", err[1]); end
    if (ff[1] !== 16'd2)  begin n_bad++; $display("FAIL single_first: %h need 2", ff[1]); end
    if (rp[1] !== 1'b0)   begin n_bad++; $display("FAIL single_pass: %b need 0", rp[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_report_stall();
    int cyc;
    model_mode = 2;
    rr[1] = 1'b0;
    start_key(1, BAD_KEY, 1'b1);
    wait_verdict(1, cyc);
    for (int i = 0; i < 20; i++) begin
      key_in[1] = 64'h1234_5678_9ABC_DEF0;
      kv[1]     = 1'b1;
      @(posedge clk); #1;
      n_cmp += 3;
      if (rv[1] !== 1'b1 || kr[1] !== 1'b0) begin
        n_bad++; $display("FAIL stall_valid_ready[%0d]: valid=%b ready=%b need 1/0", i, rv[1], kr[1]);
      end
      if (err[1] !== 16'd1 || ff[1] !== 16'd2 || rp[1] !== 1'b0) begin
        n_bad++; $display("FAIL stall_fields[%0d]: err=%h first=%h pass=%b need 1/2/0", i, err[1], ff[1], rp[1]);
      end
      if (rkey[1] !== BAD_KEY || mkey[1] !== BAD_KEY) begin
        n_bad++; $display("FAIL stall_key[%0d]: res=%h mult=%h need %h", i, rkey[1], mkey[1], BAD_KEY);
      end
    end
    kv[1] = 1'b0;
    rr[1] = 1'b1;
    @(posedge clk); #1;
    n_cmp += 2;
    if (rv[1] !== 1'b0) begin n_bad++; $display("FAIL stall_release_valid: %b need 0", rv[1]); end
    if (kr[1] !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: %b need 1", kr[1]); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    model_mode = 1;
    start_key(0, BAD_KEY, 1'b1);
    repeat (401) @(posedge clk);
    #1;
    n_cmp += 2;
    if (op1[0] !== 8'h00 || op2[0] !== 8'h64) begin
      n_bad++; $display("FAIL mid_vec100_ops: %h/%h need 00/64", op1[0], op2[0]);
    end
    if (err[0] !== 16'd100) begin n_bad++; $display("FAIL mid_err_before_rst: %0d need 100", err[0]); end
    rst = 1'b1;
    #2;
    n_cmp += 3;
    if (kr[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_idle: ready=%b busy=%b need 1/0", kr[0], busy[0]);
    end
    if (rv[0] !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: %b need 0", rv[0]); end
    if (err[0] !== 16'h0 || ff[0] !== 16'hFFFF) begin
      n_bad++; $display("FAIL mid_rst_fields: err=%h first=%h need 0/ffff", err[0], ff[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (kr[0] !== 1'b1 || rv[0] !== 1'b0) begin
      n_bad++; $display("FAIL mid_after_rst: ready=%b valid=%b need 1/0", kr[0], rv[0]);
    end
    model_mode = 2;
    start_key(0, GOOD_KEY, 1'b1);
    wait_verdict(0, cyc);
    n_cmp += 3;
    if (cyc != 1026)      begin n_bad++; $display("FAIL mid_rerun_latency: %0d need 1026", cyc); end
    if (err[0] !== 16'd1) begin n_bad++; $display("FAIL mid_rerun_err: %0d need 1", err[0]); end
    if (ff[0] !== 16'd2)  begin n_bad++; $display("FAIL mid_rerun_first: %0d need 2", ff[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_lfsr();
    logic [15:0] exp_v [4];
    int cyc;
    exp_v[0] = 16'hACE1; exp_v[1] = 16'h59C3; exp_v[2] = 16'hB387; exp_v[3] = 16'h670F;
    model_mode = 0;
    for (int k = 0; k < 2; k++) begin
      start_key(1, GOOD_KEY, 1'b0);
      @(posedge clk); #1;
      for (int v = 0; v < 4; v++) begin
        if (v != 0) begin repeat (4) @(posedge clk); #1; end
        n_cmp++;
        if ({op1[1], op2[1]} !== exp_v[v]) begin
          n_bad++; $display("FAIL lfsr_ops key%0d vec%0d: %h%h need %h", k, v, op1[1], op2[1], exp_v[v]);
        end
      end
      wait_verdict(1, cyc);
      n_cmp++;
      if (rp[1] !== 1'b1 || err[1] !== 16'h0) begin
        n_bad++; $display("FAIL lfsr_verdict key%0d: pass=%b err=%h need 1/0", k, rp[1], err[1]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      key_in[d] = 64'h0; kv[d] = 1'b0; vmode[d] = 1'b0; rr[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_pass_counter();
    test_wrong_key();
    test_single_fail();
    test_report_stall();
    test_reset_mid();
    test_lfsr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/locked_mult_key_sweeper.md
Name: locked_mult_key_sweeper

Overview:
- Sequencing controller for the key-locked 8x8 array multiplier (64-bit keyinput, 16-bit product).
- For each candidate key accepted from a host, it drives the key and a vector sequence onto the multiplier, waits a settle window, and checks each result against an internal golden product.
- It returns a per-key verdict: error count and first failing vector index.
- Sits between a key-search host (or bench) and one combinational locked multiplier instance.

Parameters:
- KEY_W, 64, width of key bus.
- NUM_VECTORS, 256, vectors applied per key (2..65536).
- SETTLE_CYCLES, 2, wait cycles between operand drive and result sample (>=1).
- LFSR_SEED, 16'hACE1, LFSR reset/restart value; 0 is replaced by 16'hACE1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- key_i  in  KEY_W  candidate key.
- key_valid_i  in  1  key offer.
- key_ready_o  out  1  controller idle, can accept key.
- vec_mode_i  in  1  0 = LFSR vectors, 1 = counter vectors; sampled at key accept.
- mult_op1_o  out  8  operand1 to multiplier.
- mult_op2_o  out  8  operand2 to multiplier.
- mult_key_o  out  KEY_W  keyinput to multiplier.
- mult_result_i  in  16  multiplier result.
- res_valid_o  out  1  verdict valid.
- res_ready_i  in  1  verdict consumed.
- res_key_o  out  KEY_W  key the verdict belongs to.
- res_err_cnt_o  out  16  mismatching vectors, saturating at 16'hFFFF.
- res_first_fail_o  out  16  index of first mismatch; 16'hFFFF if none.
- res_pass_o  out  1  high when res_err_cnt_o == 0.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0, except key_ready_o = 1 and res_first_fail_o = 16'hFFFF.
  - State IDLE; vector index 0; LFSR = seed.
- All outputs are registered.
- FSM states: IDLE, APPLY, SETTLE, CHECK, REPORT.
- IDLE:
  - key_ready_o = 1.
  - On key_valid_i & key_ready_o: latch key into mult_key_o and res_key_o, latch vec_mode_i, clear index, error count and first_fail, reload LFSR seed, go to APPLY.
- APPLY (1 cycle):
  - Counter mode: op1 = idx[15:8], op2 = idx[7:0].
  - LFSR mode: op1 = lfsr[15:8], op2 = lfsr[7:0].
  - Register golden = op1*op2 (16-bit, unsigned); go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles with operands held stable, then go to CHECK.
- CHECK (1 cycle):
  - Compare mult_result_i to golden.
  - On mismatch: err_cnt += 1 (saturating); if first_fail == 16'hFFFF, record idx.
  - If idx == NUM_VECTORS-1, go to REPORT; else idx += 1, advance LFSR one step, go to APPLY.
- LFSR: Fibonacci, shift left, feedback = b15^b13^b12^b10 into b0.
- Per-vector latency: SETTLE_CYCLES+2 cycles. Total per key: NUM_VECTORS*(SETTLE_CYCLES+2)+2 cycles including accept and REPORT entry.
- REPORT:
  - res_valid_o = 1; res_* fields stable until handshake.
  - On res_valid_o & res_ready_i: res_valid_o falls next cycle, go to IDLE.
  - If res_ready_i is already high on REPORT entry, the handshake completes in 1 cycle.
- key_valid_i while busy is ignored (key_ready_o = 0); no queueing.
- Operands and key stay at their last values in IDLE/REPORT; they are not zeroed.
- Reset mid-operation:
  - Immediate return to IDLE with reset values.
  - Any pending verdict is discarded; no partial result is emitted.
- Index wrap: NUM_VECTORS = 65536 uses the full 16-bit idx; termination is detected by compare, not overflow.
- Counter mode with NUM_VECTORS = 65536 is exhaustive.

Decomposition:
- Package locked_mult_pkg holds:
  - state enum (IDLE..REPORT);
  - LFSR taps constant and default seed 16'hACE1;
  - NO_FAIL = 16'hFFFF;
  - MULT_W = 8, RES_W = 16.
- One sub-module, mult_vec_gen: holds index counter and LFSR, has load/step inputs and mode select, outputs op1/op2.
- Golden product is inline in the top.

Test Plan:
- Ideal multiplier model, counter mode, NUM_VECTORS = 256, key 64'h4B72AAC6D650642F -> res_err_cnt_o = 0, res_first_fail_o = 16'hFFFF, res_pass_o = 1 after 1026 cycles.
- Model inverting result bit0 for any key ≠ 64'h4B72AAC6D650642F, key 64'h4B72AAC6D650640F, NUM_VECTORS = 4 -> err_cnt = 4, first_fail = 0, res_pass_o = 0.
- Counter mode, NUM_VECTORS = 4, model wrong only when op2 == 8'h02 -> err_cnt = 1, first_fail = 2.
- res_ready_i held low 20 cycles in REPORT -> res_valid_o and all res_* stable; key_valid_i during that window not accepted; verdict delivered on the first cycle res_ready_i = 1.
- rst_i asserted during SETTLE of vector 100 -> next cycle key_ready_o = 1, res_valid_o = 0; the following key run reports a fresh count from zero.
- LFSR mode, two consecutive keys -> identical op1/op2 sequences per key (seed reload); first vector is op1 = 8'hAC, op2 = 8'hE1.
